// File: rtl/byte_bitwise_unit.sv
// rtl/byte_bitwise_unit.sv - 8-bit bitwise logic slice with combinational results and a registered selected result
`timescale 1ns/1ps

// Single-bit OR gate.
module bbu_or_gate (
   input  logic a_i,
   input  logic b_i,
   output logic y_o
);
   assign y_o = a_i | b_i;
endmodule

// Single-bit AND gate.
module bbu_and_gate (
   input  logic a_i,
   input  logic b_i,
   output logic y_o
);
   assign y_o = a_i & b_i;
endmodule

// Single-bit XOR gate.
module bbu_xor_gate (
   input  logic a_i,
   input  logic b_i,
   output logic y_o
);
   assign y_o = a_i ^ b_i;
endmodule

// Single-bit inverter; NOT only looks at operand A.
module bbu_not_gate (
   input  logic a_i,
   output logic y_o
);
   assign y_o = ~a_i;
endmodule

// Byte-wide logic slice; two of these side by side form the 16-bit logic unit.
module byte_bitwise_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [1:0] op,
   input  logic       in_valid,
   output logic [7:0] or_res,
   output logic [7:0] and_res,
   output logic [7:0] xor_res,
   output logic [7:0] not_res,
   output logic [7:0] res_q,
   output logic       zero_q,
   output logic       valid_q
);

   localparam logic [1:0] OP_OR  = 2'd0;
   localparam logic [1:0] OP_AND = 2'd1;
   localparam logic [1:0] OP_XOR = 2'd2;
   localparam logic [1:0] OP_NOT = 2'd3;

   logic [7:0] sel;
   logic       zero;
   logic [7:0] res_d;
   logic       zero_d;
   logic       valid_d;

   // Bits are fully independent: one gate per bit per function, no carries.
   for (genvar i = 0; i < 8; i++) begin : g_bit
      bbu_or_gate  u_or  (.a_i(a[i]), .b_i(b[i]), .y_o(or_res[i]));
      bbu_and_gate u_and (.a_i(a[i]), .b_i(b[i]), .y_o(and_res[i]));
      bbu_xor_gate u_xor (.a_i(a[i]), .b_i(b[i]), .y_o(xor_res[i]));
      bbu_not_gate u_not (.a_i(a[i]), .y_o(not_res[i]));
   end

   // Pick the result for the registered path; every op encoding is meaningful.
   always_comb begin
      sel = or_res;
      unique case (op)
         OP_OR:   sel = or_res;
         OP_AND:  sel = and_res;
         OP_XOR:  sel = xor_res;
         OP_NOT:  sel = not_res;
         default: sel = or_res;
      endcase
      zero = ~|sel;
   end

   // Next-state: reset beats a capture; without a capture the result holds and valid drops.
   always_comb begin
      res_d   = res_q;
      zero_d  = zero_q;
      valid_d = 1'b0;
      if (rst) begin
         res_d   = 8'h00;
         zero_d  = 1'b1;
         valid_d = 1'b0;
      end else if (in_valid) begin
         res_d   = sel;
         zero_d  = zero;
         valid_d = 1'b1;
      end
   end

   // Registered result, zero flag and one-cycle valid pulse.
   always_ff @(posedge clk) begin
      res_q   <= res_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
   end

endmodule

// File: tb/tb_byte_bitwise_unit.sv
// tb/tb_byte_bitwise_unit.sv - self-checking bench for byte_bitwise_unit
`timescale 1ns/1ps

module tb_byte_bitwise_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] a;
   logic [7:0] b;
   logic [1:0] op;
   logic       in_valid;
   logic [7:0] or_res;
   logic [7:0] and_res;
   logic [7:0] xor_res;
   logic [7:0] not_res;
   logic [7:0] res_q;
   logic       zero_q;
   logic       valid_q;

   int tests = 0;
   int fails = 0;

   // Reference state of the registered path.
   logic [7:0] m_res;
   logic       m_zero;
   logic       m_valid;

   typedef struct {
      logic       rst;
      logic       in_valid;
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_res;
      logic       exp_zero;
      logic       exp_valid;
   } vec_t;

   vec_t vecs[$];

   byte_bitwise_unit dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .in_valid(in_valid),
      .or_res(or_res), .and_res(and_res), .xor_res(xor_res), .not_res(not_res),
      .res_q(res_q), .zero_q(zero_q), .valid_q(valid_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_comb(input string name);
      check(name, {or_res, and_res, xor_res, not_res}, {a | b, a & b, a ^ b, ~a});
   endtask

   function automatic logic [7:0] ref_sel(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
      case (o)
         2'd0: return x | y;
         2'd1: return x & y;
         2'd2: return x ^ y;
         default: return ~x;
      endcase
   endfunction

   task automatic add(input logic r, input logic v, input logic [1:0] o, input logic [7:0] x,
                      input logic [7:0] y, input logic [7:0] er, input logic ez, input logic ev);
      vec_t t;
      t.rst = r; t.in_valid = v; t.op = o; t.a = x; t.b = y;
      t.exp_res = er; t.exp_zero = ez; t.exp_valid = ev;
      vecs.push_back(t);
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; op = 2'd0; a = 8'h00; b = 8'h00;
      #2;

      // Directed table: each row is one clock edge with the expected state after it.
      add(1, 1, 0, 8'hFF, 8'h00, 8'h00, 1, 0);  // reset wins over in_valid
      add(0, 0, 3, 8'h00, 8'h00, 8'h00, 1, 0);  // hold with op changing
      add(0, 0, 1, 8'h11, 8'h22, 8'h00, 1, 0);
      add(0, 0, 2, 8'h33, 8'h44, 8'h00, 1, 0);
      add(0, 1, 0, 8'h02, 8'h03, 8'h03, 0, 1);  // OR
      add(0, 0, 1, 8'h02, 8'h05, 8'h03, 0, 0);  // valid pulse ends, result held
      add(0, 1, 1, 8'h02, 8'h03, 8'h02, 0, 1);  // AND nonzero
      add(0, 1, 1, 8'h02, 8'h05, 8'h00, 1, 1);  // AND zero
      add(0, 1, 2, 8'h5A, 8'hFF, 8'hA5, 0, 1);  // XOR
      add(0, 1, 3, 8'h5A, 8'h00, 8'hA5, 0, 1);  // NOT ignores b
      add(0, 1, 0, 8'hF0, 8'h3C, 8'hFC, 0, 1);  // back-to-back sequence
      add(0, 1, 1, 8'hF0, 8'h3C, 8'h30, 0, 1);
      add(0, 1, 2, 8'hF0, 8'h3C, 8'hCC, 0, 1);
      add(0, 1, 3, 8'hF0, 8'h3C, 8'h0F, 0, 1);
      add(0, 0, 0, 8'hF0, 8'h3C, 8'h0F, 0, 0);
      add(1, 1, 0, 8'h77, 8'h00, 8'h00, 1, 0);  // mid-stream reset
      add(0, 1, 0, 8'h08, 8'h02, 8'h0A, 0, 1);  // capture resumes
      add(0, 1, 3, 8'hFF, 8'h12, 8'h00, 1, 1);  // NOT of all-ones is zero

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; in_valid = vecs[i].in_valid; op = vecs[i].op;
         a = vecs[i].a; b = vecs[i].b;
         #1;
         check_comb($sformatf("vec%0d_comb", i));
         step();
         check($sformatf("vec%0d_res", i), {24'h0, res_q}, {24'h0, vecs[i].exp_res});
         check($sformatf("vec%0d_zero", i), {31'h0, zero_q}, {31'h0, vecs[i].exp_zero});
         check($sformatf("vec%0d_valid", i), {31'h0, valid_q}, {31'h0, vecs[i].exp_valid});
      end

      // Hand sequence: not_res is independent of b.
      a = 8'h5A;
      for (int j = 0; j < 4; j++) begin
         b = 8'(j * 8'h55);
         #1;
         check("not_any_b", {24'h0, not_res}, 32'h0000_00A5);
      end

      // Randomized run against a spec-level model.
      m_res = res_q; m_zero = zero_q; m_valid = valid_q;
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 31) == 0);
         in_valid = $urandom_range(0, 1);
         op = 2'($urandom_range(0, 3));
         a = 8'($urandom);
         b = ($urandom_range(0, 7) == 0) ? ~a : 8'($urandom);
         #1;
         check_comb("rand_comb");
         if (rst) begin
            m_res = 8'h00; m_valid = 1'b0;
         end else if (in_valid) begin
            m_res = ref_sel(op, a, b); m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
         m_zero = (m_res == 8'h00);
         step();
         check("rand_regs", {22'h0, res_q, zero_q, valid_q}, {22'h0, m_res, m_zero, m_valid});
      end

      // Exhaustive combinational sweep over all operand pairs.
      rst = 1'b0; in_valid = 1'b0;
      for (int k = 0; k < 65536; k++) begin
         {a, b} = 16'(k);
         #1;
         check_comb("sweep");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
